// File: rtl/fir_mac_seq_if.sv
// Sample, coefficient-write and filtered-output signals of the sequential FIR engine.
interface fir_mac_seq_if #(
    parameter int unsigned DATA_BITS = 16,
    parameter int unsigned COEF_BITS = 12,
    parameter int unsigned OUT_BITS  = 32
);
    logic                        data_in_vld;
    logic signed [DATA_BITS-1:0] data_in;
    logic                        coef_wr_en;
    logic [7:0]                  coef_wr_addr;
    logic signed [COEF_BITS-1:0] coef_wr_data;
    logic                        busy;
    logic                        overrun;
    logic                        coef_wr_drop;
    logic signed [OUT_BITS-1:0]  data_out;
    logic                        data_out_vld;

    // Producer side: supplies samples and coefficients, consumes results
    modport master (
        output data_in_vld, data_in, coef_wr_en, coef_wr_addr, coef_wr_data,
        input  busy, overrun, coef_wr_drop, data_out, data_out_vld
    );

    // Filter side
    modport slave (
        input  data_in_vld, data_in, coef_wr_en, coef_wr_addr, coef_wr_data,
        output busy, overrun, coef_wr_drop, data_out, data_out_vld
    );
endinterface

// File: rtl/fir_mac_seq.sv
// Time-multiplexed symmetric FIR: one pre-adder, one multiplier and one
// accumulator walk the half-coefficient bank over a circular sample buffer.
module fir_mac_seq #(
    parameter int unsigned DATA_BITS   = 16,
    parameter int unsigned COEF_BITS   = 12,
    parameter int unsigned EXTEND_BITS = 4,
    parameter int unsigned FIR_ORDER   = 16,
    parameter int unsigned OUT_BITS    = DATA_BITS + COEF_BITS + EXTEND_BITS
) (
    input  logic         clk,
    input  logic         rst_n,
    fir_mac_seq_if.slave bus
);
    localparam int unsigned H    = FIR_ORDER / 2;
    localparam int unsigned NTAP = FIR_ORDER + 1;
    localparam int unsigned PB   = DATA_BITS + 1;
    localparam int unsigned MB   = PB + COEF_BITS;
    localparam int unsigned BW   = $clog2(NTAP);
    localparam int unsigned KW   = $clog2(H + 1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_OUT} state_t;

    state_t                      state_q, state_d;
    logic signed [DATA_BITS-1:0] buf_q  [NTAP];
    logic signed [COEF_BITS-1:0] coef_q [H+1];
    logic [BW-1:0]               wp_q, ra_q, rb_q;
    logic [KW-1:0]               k_q;
    logic                        drain_q;
    logic signed [PB-1:0]        pre_q;
    logic signed [COEF_BITS-1:0] cf_q;
    logic signed [MB-1:0]        prod_q;
    logic signed [OUT_BITS-1:0]  acc_q;

    logic                        accept_c, issue_c, finish_c, coef_ok_c;
    logic signed [PB-1:0]        opb_c, pre_sum_c;
    logic signed [OUT_BITS-1:0]  acc_sum_c;

    // Power-on contents of the half-coefficient bank
    function automatic logic signed [COEF_BITS-1:0] coef_init(input int unsigned idx);
        case (idx)
            0:       return COEF_BITS'(8);
            1:       return COEF_BITS'(-37);
            2:       return COEF_BITS'(64);
            3:       return COEF_BITS'(-57);
            4:       return COEF_BITS'(-12);
            5:       return COEF_BITS'(145);
            6:       return COEF_BITS'(-309);
            7:       return COEF_BITS'(445);
            8:       return COEF_BITS'(1550);
            default: return '0;
        endcase
    endfunction

    function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
        return (p == BW'(FIR_ORDER)) ? '0 : p + BW'(1);
    endfunction

    function automatic logic [BW-1:0] ptr_dec(input logic [BW-1:0] p);
        return (p == '0) ? BW'(FIR_ORDER) : p - BW'(1);
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        issue_c  = 1'b0;
        finish_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.data_in_vld) begin
                    accept_c = 1'b1;
                    state_d  = S_MAC;
                end
            end
            S_MAC: begin
                issue_c = 1'b1;
                if (k_q == KW'(H)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_q) begin
                    finish_c = 1'b1;
                    state_d  = S_OUT;
                end
            end
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pre-add operands: newest-side tap plus its mirror; centre tap has no mirror
    always_comb begin
        opb_c     = (k_q == KW'(H)) ? '0 : PB'(buf_q[rb_q]);
        pre_sum_c = PB'(buf_q[ra_q]) + opb_c;
        acc_sum_c = acc_q + OUT_BITS'(prod_q);
    end

    assign coef_ok_c = bus.coef_wr_en && (state_q == S_IDLE) && (bus.coef_wr_addr <= 8'(H));

    // Sample buffer, coefficient bank, tap sequencing and MAC pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NTAP; i++) buf_q[i] <= '0;
            for (int unsigned i = 0; i <= H; i++)   coef_q[i] <= coef_init(i);
            wp_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            k_q     <= '0;
            drain_q <= 1'b0;
            pre_q   <= '0;
            cf_q    <= '0;
            prod_q  <= '0;
            acc_q   <= '0;
        end else begin
            if (accept_c) begin
                buf_q[wp_q] <= bus.data_in;
                wp_q        <= ptr_inc(wp_q);
                ra_q        <= wp_q;
                rb_q        <= ptr_inc(wp_q);
                k_q         <= '0;
                acc_q       <= '0;
            end else begin
                acc_q <= acc_sum_c;
            end
            if (issue_c) begin
                pre_q <= pre_sum_c;
                cf_q  <= coef_q[k_q];
                k_q   <= k_q + KW'(1);
                ra_q  <= ptr_dec(ra_q);
                rb_q  <= ptr_inc(rb_q);
            end else begin
                pre_q <= '0;
                cf_q  <= '0;
            end
            prod_q  <= MB'(pre_q) * MB'(cf_q);
            drain_q <= (state_q == S_DRAIN) && !drain_q;
            if (coef_ok_c) coef_q[KW'(bus.coef_wr_addr)] <= bus.coef_wr_data;
        end
    end

    // Registered status and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.busy         <= 1'b0;
            bus.overrun      <= 1'b0;
            bus.coef_wr_drop <= 1'b0;
            bus.data_out     <= '0;
            bus.data_out_vld <= 1'b0;
        end else begin
            bus.busy         <= (state_d != S_IDLE);
            bus.overrun      <= bus.data_in_vld && (state_q != S_IDLE);
            bus.coef_wr_drop <= bus.coef_wr_en && !coef_ok_c;
            bus.data_out_vld <= finish_c;
            if (finish_c) bus.data_out <= acc_sum_c;
        end
    end
endmodule
